instruction_fetch: RTL and testbench

IF stage of the 5-stage MIPS pipeline. It produces the IF/ID latch (i_pc4, i_instruction) consumed by instruction_decode, and consumes that stage's o_jump/o_jump_addr redirect. It holds a word-addressed instruction memory that is loaded word-by-word before execution. Execution is controlled by a LOAD/RUN/HALT state machine with stall, flush and single-step support.

---
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: word-addressed program memory, PC, IF/ID latch
// and the LOAD/RUN/HALT control machine with stall, flush and single-step.
module instruction_fetch #(
   parameter int          NB_ADDR_MEM = 8,
   parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_load_valid,
   input  logic [31:0]            i_load_data,
   input  logic                   i_start,
   input  logic                   i_stall,
   input  logic                   i_step_mode,
   input  logic                   i_step,
   input  logic                   i_jump,
   input  logic [31:0]            i_jump_addr,
   output logic [31:0]            o_pc,
   output logic [31:0]            o_pc4,
   output logic [31:0]            o_instruction,
   output logic [1:0]             o_state,
   output logic                   o_halted,
   output logic [NB_ADDR_MEM:0]   o_load_count,
   output logic                   o_load_full
);
   localparam int DEPTH = 2**NB_ADDR_MEM;

   typedef enum logic [1:0] {ST_LOAD = 2'b00, ST_RUN = 2'b01, ST_HALT = 2'b10} state_t;

   state_t                 state_q, state_d;
   logic [31:0]            pc_q, pc_d, pc4_q, pc4_d, ins_q, ins_d;
   logic [NB_ADDR_MEM:0]   cnt_q, cnt_d;
   logic [31:0]            mem [DEPTH];
   logic [NB_ADDR_MEM-1:0] idx;
   logic [31:0]            fetch_word;
   logic                   load_full;
   logic                   mem_we;

   // Upper PC bits are dropped, so fetch wraps around the memory.
   assign idx        = pc_q[NB_ADDR_MEM+1:2];
   assign fetch_word = mem[idx];
   // Count never exceeds DEPTH, so its MSB alone marks a full memory.
   assign load_full  = cnt_q[NB_ADDR_MEM];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      ins_d   = ins_q;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;
      case (state_q)
         ST_LOAD: begin
            ins_d = NOP_WORD;
            if (i_load_valid && !load_full) begin
               mem_we = 1'b1;
               cnt_d  = cnt_q + 1'b1;
            end
            if (i_start) begin
               state_d = ST_RUN;
               pc_d    = '0;
            end
         end
         ST_RUN: begin
            if (!i_stall) begin
               if (i_jump) begin
                  pc_d  = i_jump_addr;
                  ins_d = NOP_WORD;
               end else if (!i_step_mode || i_step) begin
                  ins_d = fetch_word;
                  pc4_d = pc_q + 32'd4;
                  // The halt word issues once but leaves the PC parked on it.
                  if (fetch_word == HALT_WORD) state_d = ST_HALT;
                  else                         pc_d    = pc_q + 32'd4;
               end else begin
                  ins_d = NOP_WORD;
               end
            end
         end
         ST_HALT: begin
            ins_d = NOP_WORD;
            if (i_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state_q <= ST_LOAD;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pc_q  <= '0;
         pc4_q <= '0;
         ins_q <= NOP_WORD;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         pc4_q <= pc4_d;
         ins_q <= ins_d;
         cnt_q <= cnt_d;
      end
   end

   // Program memory survives reset.
   always_ff @(posedge i_clk) begin
      if (mem_we) mem[cnt_q[NB_ADDR_MEM-1:0]] <= i_load_data;
   end

   assign o_pc          = pc_q;
   assign o_pc4         = pc4_q;
   assign o_instruction = ins_q;
   assign o_state       = state_q;
   assign o_halted      = (state_q == ST_HALT);
   assign o_load_count  = cnt_q;
   assign o_load_full   = load_full;
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: per-cycle expectations queued with the stimulus
// and compared one edge later.
module tb_instruction_fetch;
   localparam int NB = 4;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic          i_clk = 1'b0;
   logic          i_reset, i_load_valid, i_start, i_stall, i_step_mode, i_step, i_jump;
   logic [31:0]   i_load_data, i_jump_addr;
   logic [31:0]   o_pc, o_pc4, o_instruction;
   logic [1:0]    o_state;
   logic          o_halted, o_load_full;
   logic [NB:0]   o_load_count;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] ins;
      logic [1:0]  st;
   } exp_t;
   exp_t sb[$];

   instruction_fetch #(.NB_ADDR_MEM(NB)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_load_valid(i_load_valid), .i_load_data(i_load_data),
      .i_start(i_start), .i_stall(i_stall), .i_step_mode(i_step_mode), .i_step(i_step),
      .i_jump(i_jump), .i_jump_addr(i_jump_addr), .o_pc(o_pc), .o_pc4(o_pc4),
      .o_instruction(o_instruction), .o_state(o_state), .o_halted(o_halted),
      .o_load_count(o_load_count), .o_load_full(o_load_full)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Queue what the outputs must be after the next edge, clock, then retire it.
   task automatic expect_cyc(input logic [31:0] pc, input logic [31:0] pc4,
                             input logic [31:0] ins, input logic [1:0] st);
      exp_t e;
      sb.push_back('{pc, pc4, ins, st});
      tick();
      e = sb.pop_front();
      chk("pc",    o_pc,          e.pc);
      chk("pc4",   o_pc4,         e.pc4);
      chk("instr", o_instruction, e.ins);
      chk("state", {30'd0, o_state}, {30'd0, e.st});
   endtask

   function automatic logic [31:0] w(input int i);
      return (i == 10) ? HALT : (32'h2000_0000 | i);
   endfunction

   initial begin
      i_reset = 1'b0; i_load_valid = 0; i_load_data = 0; i_start = 0; i_stall = 0;
      i_step_mode = 0; i_step = 0; i_jump = 0; i_jump_addr = 0;
      #12;
      chk("rst_pc", o_pc, 0);
      chk("rst_pc4", o_pc4, 0);
      chk("rst_instr", o_instruction, 0);
      chk("rst_state", {30'd0, o_state}, 0);
      chk("rst_halted", {31'd0, o_halted}, 0);
      chk("rst_count", {27'd0, o_load_count}, 0);
      chk("rst_full", {31'd0, o_load_full}, 0);
      @(negedge i_clk); i_reset = 1'b1;

      // Program 1: halt at word 2, start together with the last write.
      for (int i = 0; i <= 10; i++) begin
         i_load_valid = 1; i_load_data = (i == 2) ? HALT : w(i); i_start = (i == 10);
         tick();
      end
      i_load_valid = 0; i_start = 0;
      chk("start_count", {27'd0, o_load_count}, 11);
      chk("start_state", {30'd0, o_state}, 1);
      chk("start_instr", o_instruction, 0);
      expect_cyc(32'h4, 32'h4, w(0), 2'b01);
      expect_cyc(32'h8, 32'h8, w(1), 2'b01);
      expect_cyc(32'h8, 32'hC, HALT, 2'b10);
      chk("halted", {31'd0, o_halted}, 1);
      expect_cyc(32'h8, 32'hC, 32'h0, 2'b10);

      // HALT -> LOAD, overwrite first three words, removing the early halt.
      i_start = 1; tick(); i_start = 0;
      chk("reload_state", {30'd0, o_state}, 0);
      chk("reload_count", {27'd0, o_load_count}, 0);
      for (int i = 0; i < 3; i++) begin
         i_load_valid = 1; i_load_data = w(i); i_start = (i == 2);
         tick();
      end
      i_load_valid = 0; i_start = 0;
      chk("run2_pc", o_pc, 0);
      expect_cyc(32'h4, 32'h4, w(0), 2'b01);
      i_stall = 1;
      expect_cyc(32'h4, 32'h4, w(0), 2'b01);
      expect_cyc(32'h4, 32'h4, w(0), 2'b01);
      i_stall = 0;
      expect_cyc(32'h8, 32'h8, w(1), 2'b01);
      i_stall = 1; i_jump = 1; i_jump_addr = 32'h20;
      expect_cyc(32'h8, 32'h8, w(1), 2'b01);
      i_stall = 0;
      expect_cyc(32'h20, 32'h8, 32'h0, 2'b01);
      i_jump = 0;
      expect_cyc(32'h24, 32'h24, w(8), 2'b01);

      // Step mode: bubbles between pulses, jump still honoured while idle.
      i_step_mode = 1;
      expect_cyc(32'h24, 32'h24, 32'h0, 2'b01);
      expect_cyc(32'h24, 32'h24, 32'h0, 2'b01);
      i_step = 1;
      expect_cyc(32'h28, 32'h28, w(9), 2'b01);
      i_step = 0; i_jump = 1; i_jump_addr = 32'hC;
      expect_cyc(32'hC, 32'h28, 32'h0, 2'b01);
      i_jump = 0;
      expect_cyc(32'hC, 32'h28, 32'h0, 2'b01);
      i_step = 1;
      expect_cyc(32'h10, 32'h10, w(3), 2'b01);
      i_step = 0; i_step_mode = 0;

      // Unaligned target indexes word 10, which is the halt word.
      i_jump = 1; i_jump_addr = 32'h2B;
      expect_cyc(32'h2B, 32'h10, 32'h0, 2'b01);
      i_jump = 0;
      expect_cyc(32'h2B, 32'h2F, HALT, 2'b10);
      i_jump = 1; i_jump_addr = 0; i_step = 1; i_stall = 1;
      expect_cyc(32'h2B, 32'h2F, 32'h0, 2'b10);
      i_jump = 0; i_step = 0; i_stall = 0;

      // HALT -> LOAD -> RUN without loading, then async reset mid-cycle.
      i_start = 1; tick(); tick(); i_start = 0;
      chk("run3_state", {30'd0, o_state}, 1);
      chk("run3_pc", o_pc, 0);
      expect_cyc(32'h4, 32'h4, w(0), 2'b01);
      #3 i_reset = 1'b0;
      #1;
      chk("arst_pc", o_pc, 0);
      chk("arst_pc4", o_pc4, 0);
      chk("arst_instr", o_instruction, 0);
      chk("arst_state", {30'd0, o_state}, 0);
      @(negedge i_clk); i_reset = 1'b1;
      i_start = 1; tick(); i_start = 0;
      expect_cyc(32'h4, 32'h4, w(0), 2'b01);
      expect_cyc(32'h8, 32'h8, w(1), 2'b01);

      // Overfill: 18 words into a 16-word memory.
      @(negedge i_clk); i_reset = 1'b0;
      @(negedge i_clk); i_reset = 1'b1;
      for (int i = 0; i < 18; i++) begin
         i_load_valid = 1; i_load_data = 32'h3000_0000 | i;
         tick();
         if (i == 14) chk("full_early", {31'd0, o_load_full}, 0);
      end
      i_load_valid = 0;
      chk("full_count", {27'd0, o_load_count}, 16);
      chk("full_flag", {31'd0, o_load_full}, 1);
      i_start = 1; tick(); i_start = 0;
      expect_cyc(32'h4, 32'h4, 32'h3000_0000, 2'b01);
      expect_cyc(32'h8, 32'h8, 32'h3000_0001, 2'b01);
      i_jump = 1; i_jump_addr = 32'h3C;
      expect_cyc(32'h3C, 32'h8, 32'h0, 2'b01);
      i_jump = 0;
      expect_cyc(32'h40, 32'h40, 32'h3000_000F, 2'b01);
      expect_cyc(32'h44, 32'h44, 32'h3000_0000, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
